// File: rtl/ram_arbiter.sv
// Arbitrates the CPU bus port and the video fetch port onto a single-port
// synchronous work RAM with one-cycle registered read latency.
module ram_arbiter #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_as,
  input  logic          cpu_rw,
  input  logic          cpu_uds,
  input  logic          cpu_lds,
  input  logic [AW:1]   cpu_addr,
  input  logic [15:0]   cpu_wdata,
  output logic [15:0]   cpu_rdata,
  output logic          cpu_dtack,
  input  logic          vid_req,
  input  logic [AW:1]   vid_addr,
  output logic [15:0]   vid_data,
  output logic          vid_ack,
  output logic          ram_we,
  output logic          ram_ub,
  output logic          ram_lb,
  output logic [AW:1]   ram_addr,
  output logic [15:0]   ram_din,
  input  logic [15:0]   ram_dout,
  output logic [1:0]    dbg_state
);

  // Handshakes: a CPU access is requested while cpu_as=1 and is acknowledged
  // by cpu_dtack, which holds until the cycle after cpu_as is sampled low; a
  // one-cycle vid_req is answered by exactly one vid_ack pulse with vid_data.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VCAP = 2'd1,
    S_CCAP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_vid_pend;
  logic        r_cpu_done;
  logic        r_last_vid;
  logic        r_cpu_rd;
  logic        r_vid_ack;
  logic [15:0] r_cpu_rdata;
  logic [15:0] r_vid_data;

  logic        w_cpu_pend;
  logic        w_cpu_win;
  logic        w_idle;
  logic        w_issue_cpu;
  logic        w_issue_vid;

  always_comb begin
    w_cpu_pend  = cpu_as & ~r_cpu_done;
    // The CPU only beats a pending fetch when video took the previous slot.
    w_cpu_win   = w_cpu_pend & (~r_vid_pend | r_last_vid);
    w_idle      = (r_state == S_IDLE) & ~reset;
    w_issue_cpu = w_idle & w_cpu_win;
    w_issue_vid = w_idle & r_vid_pend & ~w_cpu_win;

    w_next   = r_state;
    ram_we   = 1'b0;
    ram_ub   = 1'b0;
    ram_lb   = 1'b0;
    ram_addr = cpu_addr;
    ram_din  = cpu_wdata;

    case (r_state)
      S_IDLE: begin
        if (w_issue_vid) begin
          w_next   = S_VCAP;
          ram_addr = vid_addr;
        end else if (w_issue_cpu) begin
          w_next = S_CCAP;
          ram_we = ~cpu_rw;
          ram_ub = cpu_uds;
          ram_lb = cpu_lds;
        end
      end
      S_VCAP:  w_next = S_IDLE;
      S_CCAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_vid_pend  <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_last_vid  <= 1'b0;
      r_cpu_rd    <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_cpu_rdata <= 16'h0000;
      r_vid_data  <= 16'h0000;
    end else begin
      r_state <= w_next;

      // Strobes arriving while a fetch is pending or in VCAP are dropped.
      if (w_issue_vid)
        r_vid_pend <= 1'b0;
      else if (vid_req && r_state != S_VCAP)
        r_vid_pend <= 1'b1;

      if (w_issue_vid)
        r_last_vid <= 1'b1;
      else if (w_issue_cpu)
        r_last_vid <= 1'b0;

      if (w_issue_cpu)
        r_cpu_rd <= cpu_rw;

      if (!cpu_as)
        r_cpu_done <= 1'b0;
      else if (r_state == S_CCAP)
        r_cpu_done <= 1'b1;

      r_vid_ack <= (r_state == S_VCAP);
      if (r_state == S_VCAP)
        r_vid_data <= ram_dout;
      if (r_state == S_CCAP && r_cpu_rd)
        r_cpu_rdata <= ram_dout;
    end
  end

  assign cpu_dtack = r_cpu_done;
  assign cpu_rdata = r_cpu_rdata;
  assign vid_ack   = r_vid_ack;
  assign vid_data  = r_vid_data;
  assign dbg_state = r_state;

endmodule
